// File: rtl/div_iter_unit_pkg.sv
// Shared encodings and constants for the iterative divider.
package div_iter_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // FSM encodings; also visible on the debug state port.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to apply the sign fix-up to the finished quotient and remainder.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  // Negate when requested; the most negative value maps to itself, which is
  // exactly the unsigned magnitude the iteration needs.
  always_comb begin
    dout = din;
    if (neg) begin
      dout = {WIDTH{1'b0}} - din;
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} = {HI, LO}.
//
// Handshake: the requester holds opn_valid with stable operands; the unit
// accepts on the first IDLE edge where opn_valid=1 and flush=0. When the
// result is ready, res_valid rises and stays high with result stable until an
// edge with res_ready=1 completes the transfer. flush aborts at any edge and
// wins over both accept and completion; rst (async, active-low) wins over all.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
  input  logic                 opn_valid,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           dbg_state
);

  // The counter runs 0..WIDTH-1 over the quotient-bit edges; one extra
  // edge at WIDTH applies the sign fix-up from registered values, which keeps
  // the negate off the iteration path.
  localparam logic [CNT_W-1:0] CNT_FIX = CNT_W'(WIDTH);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend bits out at top, quotient bits in at bottom
  logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic                 quot_neg_q, quot_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic [WIDTH:0]       r_shift;
  logic                 q_bit;
  logic [WIDTH-1:0]     r_next;

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .din  (a),
    .neg  (sign & a[WIDTH-1]),
    .dout (mag_a)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .din  (b),
    .neg  (sign & b[WIDTH-1]),
    .dout (mag_b)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .din  (dvd_q),
    .neg  (quot_neg_q),
    .dout (quot_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .din  (rem_q),
    .neg  (rem_neg_q),
    .dout (rem_fix)
  );

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The shifted value is WIDTH+1 bits; after a successful subtract the result
  // is below the divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    r_shift = {rem_q, dvd_q[WIDTH-1]};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_next  = r_shift[WIDTH-1:0];
    if (q_bit) begin
      r_next = r_shift[WIDTH-1:0] - dvs_q;
    end
  end

  // Next-state, datapath and registered-output logic for IDLE/BUSY/DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;

    if (flush) begin
      // Abort: drop any in-flight op; the last completed result is kept.
      state_d     = DIV_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (opn_valid) begin
            dvd_d      = mag_a;
            dvs_d      = mag_b;
            quot_neg_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_d  = sign & a[WIDTH-1];
            rem_d      = '0;
            cnt_d      = '0;
            state_d    = DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (cnt_q == CNT_FIX) begin
            result_d    = {rem_fix, quot_fix};
            res_valid_d = 1'b1;
            state_d     = DIV_DONE;
          end else begin
            rem_d = r_next;
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DIV_DONE: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = DIV_IDLE;
          end
        end
        default: begin
          state_d     = DIV_IDLE;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
    end
  end

  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: arithmetic reference model, scoreboard
// queue, per-cycle compare process and hand-computed literal expectations.
module tb_div_iter_unit;
  import div_iter_unit_pkg::*;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            sign;
  logic            opn_valid;
  logic            res_ready;
  logic            res_valid;
  logic [2*W-1:0]  result;
  logic [1:0]      dbg_state;

  int              checks = 0;
  int              errors = 0;
  logic [2*W-1:0]  exp_q[$];
  logic [2*W-1:0]  last_res = '0;

  div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .opn_valid (opn_valid),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero; divide by
  // zero yields an all-ones magnitude quotient and the dividend as remainder.
  function automatic logic [63:0] model(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic s_i);
    logic [31:0] q;
    logic [31:0] r;
    longint      sa;
    longint      sb;
    if (!s_i) begin
      if (b_i == 0) begin
        q = 32'hFFFF_FFFF;
        r = a_i;
      end else begin
        q = a_i / b_i;
        r = a_i % b_i;
      end
    end else begin
      sa = longint'($signed(a_i));
      sb = longint'($signed(b_i));
      if (sb == 0) begin
        q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        r = a_i;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end
    return {r, q};
  endfunction

  // Compare process: while valid, result must equal the scoreboard head;
  // otherwise it must hold the last completed result.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      last_res = '0;
    end else if (res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        chk("sb_result", result, exp_q[0]);
        if (res_ready) last_res = exp_q.pop_front();
      end
    end else begin
      chk("result_hold", result, last_res);
    end
  end

  // Driver: issue one op, measure latency, hold res_ready low for 'hold'
  // cycles in DONE, then complete the handshake.
  task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i,
                       input logic [63:0] lit, input int hold);
    int n;
    a = a_i;
    b = b_i;
    sign = s_i;
    opn_valid = 1'b1;
    exp_q.push_back(model(a_i, b_i, s_i));
    @(posedge clk); #1;
    opn_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sign = 1'($urandom_range(0, 1));
    chk("accept_busy", 64'(dbg_state), 64'(DIV_BUSY));
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd33);
    chk("literal_result", result, lit);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("valid_drop", 64'(res_valid), 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    sign = 1'b0;
    opn_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(res_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(DIV_IDLE));
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // basic unsigned and signed cases
    do_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 0);
    do_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0);
    do_op(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 0);
    // overflow and divide by zero
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0);
    do_op(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 0);
    do_op(32'hFFFFFFFB, 32'd0, 1'b1, 64'hFFFFFFFB_00000001, 0);
    do_op(32'hFFFFFFFF, 32'd16, 1'b0, 64'h0000000F_0FFFFFFF, 0);

    // stall in DONE, then back-to-back accept on the next edge
    do_op(32'd1000, 32'd33, 1'b0, 64'h0000000A_0000001E, 5);
    do_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0);

    // flush at BUSY cycle 10 with a concurrent opn_valid
    a = 32'd100; b = 32'd7; sign = 1'b0; opn_valid = 1'b1;
    @(posedge clk); #1;
    opn_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    opn_valid = 1'b1;
    a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0;
    opn_valid = 1'b0;
    chk("flush_idle", 64'(dbg_state), 64'(DIV_IDLE));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op(32'd20, 32'd6, 1'b0, 64'h00000002_00000003, 0);

    // async reset in the middle of BUSY
    a = 32'd50; b = 32'd5; sign = 1'b0; opn_valid = 1'b1;
    exp_q.push_back(model(32'd50, 32'd5, 1'b0));
    @(posedge clk); #1;
    opn_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(DIV_IDLE));
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
